// File: rtl/synapse_config_loader.sv
`default_nettype none
// ============================================================================
// synapse_config_loader: FIFO-fed sequencer that shifts config words into the
// synapse daisy-chain. Optional macro CFG_READBACK_EN adds chain-tail readback.
// Revision: 1.0
// ============================================================================
module synapse_config_loader #(
  parameter int WORD_LENGTH = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CLK_DIV     = 2,
  parameter int CNT_W       = 10,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [WORD_LENGTH-1:0] wr_data_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       num_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   underrun_o,
  output logic                   cfg_clk_o,
  output logic [WORD_LENGTH-1:0] cfg_data_o
`ifdef CFG_READBACK_EN
  ,
  input  logic [WORD_LENGTH-1:0] cfg_ret_i,
  output logic                   rb_valid_o,
  output logic [WORD_LENGTH-1:0] rb_data_o
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [WORD_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic                   fifo_empty, fifo_full, push, pop;
  logic [WORD_LENGTH-1:0] fifo_head;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [TW-1:0]          stall_q, stall_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic                   underrun_q, underrun_d;
  logic [WORD_LENGTH-1:0] cfg_data_q, cfg_data_d;
  logic                   cfg_clk_q, busy_q, done_q;
  logic                   div_last;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = wr_valid_i && !fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
  assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    stall_d    = stall_q;
    rem_d      = rem_q;
    underrun_d = underrun_q;
    cfg_data_d = cfg_data_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          underrun_d = 1'b0;
          if (num_words_i == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = num_words_i;
            div_d   = '0;
            stall_d = '0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              cfg_data_d = fifo_head;
              state_d    = S_LOW;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_LOW: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_last) begin
          div_d   = '0;
          stall_d = '0;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            cfg_data_d = fifo_head;
            state_d    = S_LOW;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_WAIT: begin
        // A late word wins over a timeout expiring in the same cycle
        if (!fifo_empty) begin
          pop        = 1'b1;
          cfg_data_d = fifo_head;
          stall_d    = '0;
          state_d    = S_LOW;
        end else if (stall_q == TW'(TIMEOUT - 1)) begin
          underrun_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          stall_d = stall_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state so cfg_clk is a clean flop output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      stall_q    <= '0;
      rem_q      <= '0;
      underrun_q <= 1'b0;
      cfg_data_q <= '0;
      cfg_clk_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      stall_q    <= stall_d;
      rem_q      <= rem_d;
      underrun_q <= underrun_d;
      cfg_data_q <= cfg_data_d;
      cfg_clk_q  <= (state_d == S_HIGH);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign wr_ready_o = !fifo_full;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign underrun_o = underrun_q;
  assign cfg_clk_o  = cfg_clk_q;
  assign cfg_data_o = cfg_data_q;

`ifdef CFG_READBACK_EN
  logic                   rb_valid_q;
  logic [WORD_LENGTH-1:0] rb_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= (state_q == S_LOW) && div_last;
      if ((state_q == S_LOW) && div_last) begin
        rb_data_q <= cfg_ret_i;
      end
    end
  end

  assign rb_valid_o = rb_valid_q;
  assign rb_data_o  = rb_data_q;
`endif

endmodule
`default_nettype wire
